jtdsp16_yaau: RTL and testbench
===============================

JTDSP16_YAAU -- requirements
Module: jtdsp16_yaau

Interface
REQ-001 SHALL provide parameter AW, default 16, width of the pointer, offset and RAM-address datapath.
REQ-002 SHALL provide: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide: clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL provide: cen  input  1  clock enable; no state changes when low.
REQ-005 SHALL provide: ram_access  input  1  current instruction performs a Y-space RAM access.
REQ-006 SHALL provide: y_field  input  4  [1:0] select r0..r3; [3:2] modifier: 00 *rN, 01 *rN++, 10 *rN--, 11 *rN++j.
REQ-007 SHALL provide: reg_load  input  1  write the register selected by reg_sel from load_data.
REQ-008 SHALL provide: reg_sel  input  3  register select: 0-3 r0..r3, 4 j, 5 k, 6 rb, 7 re.
REQ-009 SHALL provide: load_data  input  AW  data for register writes (long immediate or bus value).
REQ-010 SHALL provide: ram_addr  output  AW  Y-space RAM address sent to the data RAM feeding the DAU ram_dout.
REQ-011 SHALL provide: reg_dout  output  AW  value of the register selected by reg_sel, combinational.
REQ-012 SHALL provide: wrap  output  1  registered; high for one cen cycle after a circular-buffer wrap.

Function
REQ-013 ram_addr SHALL equal the selected pointer rN before modification, combinationally from y_field[1:0], with zero added latency.
REQ-014 Post-modification SHALL occur only when cen is high and ram_access is high.
REQ-015 Modifier 00 SHALL leave rN unchanged.
REQ-016 Modifier 01 SHALL set rN to rN+1, modulo 2^AW.
REQ-017 Modifier 10 SHALL set rN to rN-1, modulo 2^AW.
REQ-018 Modifier 11 SHALL set rN to rN+j, with j treated as two's complement, modulo 2^AW.
REQ-019 Circular mode SHALL be active when re is nonzero.
REQ-020 In circular mode, modifier 01 with rN==re SHALL load rb into rN instead of rN+1, and SHALL set wrap high on the next cycle.
REQ-021 Modifiers 10 and 11 SHALL never wrap, regardless of rb and re.
REQ-022 When re is zero, modifier 01 SHALL increment linearly and wrap SHALL stay low.
REQ-023 wrap SHALL be cleared on the next cen cycle that has no wrap event.
REQ-024 reg_load with cen high SHALL write load_data into the register selected by reg_sel on the clock edge.
REQ-025 If reg_load and a post-modify target the same rN in the same cycle, the load SHALL win and the post-modify SHALL be discarded.
REQ-026 A post-modify or wrap in the same cycle as a load of rb, re or j SHALL use the old (pre-load) value.
REQ-027 Loads of other registers SHALL not block a post-modify of rN.
REQ-028 k SHALL be stored and readable only; it is reserved for the compound Z-mode addressing modes.

Reset
REQ-029 rst high SHALL asynchronously clear r0..r3, j, k, rb, re and wrap to 0.
REQ-030 While rst is high, ram_addr SHALL be 0 and reg_dout SHALL be 0.
REQ-031 A reset asserted mid-operation SHALL abort any pending modification; the first cen edge after release behaves as a fresh cycle.

Structure
REQ-032 The reg_sel codes and the y_field modifier codes SHALL be defined as constants in the shared jtdsp16 include header, used by this block and the instruction decoder.
REQ-033 The block SHALL contain one sub-module, jtdsp16_ptr_mod: a combinational next-pointer calculator taking rN, modifier, j, rb and re, and returning next_rN and wrap_evt.
REQ-034 All pointer registers SHALL be single flat registers; no memory arrays.

Verification
REQ-035 Reset, then reg_load r2=0x0100, then ram_access y_field=0b0110 (r2++) three times -> ram_addr 0x0100, 0x0101, 0x0102; final r2=0x0103.
REQ-036 Load rb=0x0010, re=0x0013, r0=0x0012, then four r0++ accesses -> ram_addr 0x0012, 0x0013, 0x0010, 0x0011; wrap high exactly once, in the cycle after address 0x0013.
REQ-037 Load j=0xFFFE, r1=0x0005, then two *r1++j accesses -> ram_addr 0x0005, 0x0003; r1=0x0001; no wrap even with re=0x0003.
REQ-038 r3=0x0000, r3-- access -> r3=0xFFFF; then reg_load r3=0x0040 together with an r3++ access -> r3=0x0040 (load wins).
REQ-039 cen low with ram_access and reg_load active -> no register change; rst pulse mid-sequence -> all registers and wrap read back 0 via reg_dout.

Source files
------------

// File: rtl/jtdsp16_yaau_pkg.sv
// jtdsp16_yaau_pkg: register-select and Y-field modifier codes shared by the YAAU and the instruction decoder
package jtdsp16_yaau_pkg;
    typedef enum logic [1:0] {
        MOD_NONE = 2'b00,
        MOD_INC  = 2'b01,
        MOD_DEC  = 2'b10,
        MOD_ADDJ = 2'b11
    } mod_e;
    typedef enum logic [2:0] {
        REG_R0 = 3'd0,
        REG_R1 = 3'd1,
        REG_R2 = 3'd2,
        REG_R3 = 3'd3,
        REG_J  = 3'd4,
        REG_K  = 3'd5,
        REG_RB = 3'd6,
        REG_RE = 3'd7
    } reg_e;
endpackage

// File: rtl/jtdsp16_yaau_if.sv
// jtdsp16_yaau_if: control and data bus between the sequencer/decoder and the Y address unit
interface jtdsp16_yaau_if #(parameter int AW = 16);
    logic          cen;
    logic          ram_access;
    logic [3:0]    y_field;
    logic          reg_load;
    logic [2:0]    reg_sel;
    logic [AW-1:0] load_data;
    logic [AW-1:0] ram_addr;
    logic [AW-1:0] reg_dout;
    logic          wrap;
    modport master(output cen, ram_access, y_field, reg_load, reg_sel, load_data,
                   input  ram_addr, reg_dout, wrap);
    modport slave (input  cen, ram_access, y_field, reg_load, reg_sel, load_data,
                   output ram_addr, reg_dout, wrap);
endinterface

// File: rtl/jtdsp16_ptr_mod.sv
// jtdsp16_ptr_mod: combinational next-pointer calculator with circular-buffer wrap on post-increment
module jtdsp16_ptr_mod
    import jtdsp16_yaau_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic [AW-1:0] rn,
    input  mod_e          mod,
    input  logic [AW-1:0] j,
    input  logic [AW-1:0] rb,
    input  logic [AW-1:0] re,
    output logic [AW-1:0] next_rn,
    output logic          wrap_evt
);
    always_comb begin
        // only *rN++ honours the circular buffer; a zero re disables it
        wrap_evt = mod == MOD_INC && re != '0 && rn == re;
        next_rn  = mod == MOD_INC  ? (wrap_evt ? rb : rn + AW'(1)) :
                   mod == MOD_DEC  ? rn - AW'(1) :
                   mod == MOD_ADDJ ? rn + j : rn;
    end
endmodule

// File: rtl/jtdsp16_yaau.sv
// jtdsp16_yaau: Y-space address arithmetic unit; pointers r0..r3 with post-modify, j step, k, and rb/re circular buffer
module jtdsp16_yaau
    import jtdsp16_yaau_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic               clk,
    input  logic               rst,
    jtdsp16_yaau_if.slave      bus
);
    logic [AW-1:0] r0, r1, r2, r3, j, k, rb, re;
    logic [AW-1:0] cur, nxt;
    logic [1:0]    sel;
    mod_e          mod;
    logic          wrap_evt, wrap_q, ld_hit;

    assign sel = bus.y_field[1:0];
    assign mod = mod_e'(bus.y_field[3:2]);
    assign ld_hit = bus.reg_load && bus.reg_sel == {1'b0, sel};

    always_comb cur = sel == 2'd0 ? r0 : sel == 2'd1 ? r1 : sel == 2'd2 ? r2 : r3;

    assign bus.ram_addr = cur;
    assign bus.wrap     = wrap_q;

    always_comb begin
        bus.reg_dout = re;
        case (reg_e'(bus.reg_sel))
            REG_R0: bus.reg_dout = r0;
            REG_R1: bus.reg_dout = r1;
            REG_R2: bus.reg_dout = r2;
            REG_R3: bus.reg_dout = r3;
            REG_J:  bus.reg_dout = j;
            REG_K:  bus.reg_dout = k;
            REG_RB: bus.reg_dout = rb;
            REG_RE: bus.reg_dout = re;
        endcase
    end

    jtdsp16_ptr_mod #(.AW(AW)) u_ptr_mod (
        .rn       (cur),
        .mod      (mod),
        .j        (j),
        .rb       (rb),
        .re       (re),
        .next_rn  (nxt),
        .wrap_evt (wrap_evt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0     <= '0;
            r1     <= '0;
            r2     <= '0;
            r3     <= '0;
            j      <= '0;
            k      <= '0;
            rb     <= '0;
            re     <= '0;
            wrap_q <= 1'b0;
        end else if (bus.cen) begin
            // a load of the same pointer wins and also suppresses that access's wrap
            if (bus.ram_access && !ld_hit) begin
                case (sel)
                    2'd0: r0 <= nxt;
                    2'd1: r1 <= nxt;
                    2'd2: r2 <= nxt;
                    2'd3: r3 <= nxt;
                endcase
            end
            if (bus.reg_load) begin
                case (reg_e'(bus.reg_sel))
                    REG_R0: r0 <= bus.load_data;
                    REG_R1: r1 <= bus.load_data;
                    REG_R2: r2 <= bus.load_data;
                    REG_R3: r3 <= bus.load_data;
                    REG_J:  j  <= bus.load_data;
                    REG_K:  k  <= bus.load_data;
                    REG_RB: rb <= bus.load_data;
                    REG_RE: re <= bus.load_data;
                endcase
            end
            wrap_q <= bus.ram_access && wrap_evt && !ld_hit;
        end
    end
endmodule

// File: tb/tb_jtdsp16_yaau.sv
// tb_jtdsp16_yaau: directed and randomized checks of the Y address unit against a register-file model
module tb_jtdsp16_yaau;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    int wrap_cnt = 0;
    logic [15:0] m[8];
    logic m_wrap;
    logic [15:0] last_addr;
    logic [15:0] exp_a[4];

    jtdsp16_yaau_if #(.AW(16)) ifc();
    jtdsp16_yaau #(.AW(16)) dut (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = 16'h0;
        m_wrap = 1'b0;
    endtask

    // m[] holds r0..r3, j, k, rb, re indexed by reg_sel code
    task automatic step(input logic c, input logic ra, input logic [3:0] yf,
                        input logic ld, input logic [2:0] rs, input logic [15:0] d);
        logic [15:0] p, nv;
        logic w;
        int s;
        @(negedge clk);
        ifc.cen = c;
        ifc.ram_access = ra;
        ifc.y_field = yf;
        ifc.reg_load = ld;
        ifc.reg_sel = rs;
        ifc.load_data = d;
        #1;
        s = int'(yf[1:0]);
        last_addr = ifc.ram_addr;
        chk("ram_addr", ifc.ram_addr, m[s]);
        chk("reg_dout", ifc.reg_dout, m[rs]);
        p = m[s];
        w = 1'b0;
        case (yf[3:2])
            2'b01: if (m[7] != 16'h0 && p == m[7]) begin nv = m[6]; w = 1'b1; end else nv = p + 16'd1;
            2'b10: nv = p - 16'd1;
            2'b11: nv = p + m[4];
            default: nv = p;
        endcase
        if (!ra || (ld && int'(rs) == s)) w = 1'b0;
        @(posedge clk);
        if (c) begin
            if (ra) m[s] = nv;
            if (ld) m[rs] = d;
            m_wrap = w;
        end
        #1;
        chk("wrap", {15'h0, ifc.wrap}, {15'h0, m_wrap});
        if (ifc.wrap) wrap_cnt++;
    endtask

    task automatic load(input logic [2:0] rs, input logic [15:0] d);
        step(1'b1, 1'b0, 4'b0000, 1'b1, rs, d);
    endtask

    task automatic rd(input logic [2:0] rs, input logic [15:0] exp, input string tag);
        @(negedge clk);
        ifc.cen = 1'b0;
        ifc.ram_access = 1'b0;
        ifc.reg_load = 1'b0;
        ifc.reg_sel = rs;
        #1;
        chk(tag, ifc.reg_dout, exp);
    endtask

    initial begin
        ifc.cen = 1'b1;
        ifc.ram_access = 1'b1;
        ifc.y_field = 4'b0101;
        ifc.reg_load = 1'b1;
        ifc.reg_sel = 3'd0;
        ifc.load_data = 16'hABCD;
        model_reset();
        #22;
        for (int i = 0; i < 8; i++) begin
            ifc.reg_sel = 3'(i);
            ifc.y_field = 4'(i);
            #1;
            chk("rst_reg_dout", ifc.reg_dout, 16'h0);
            chk("rst_ram_addr", ifc.ram_addr, 16'h0);
        end
        chk("rst_wrap", {15'h0, ifc.wrap}, 16'h0);
        ifc.cen = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        load(3'd2, 16'h0100);
        exp_a = '{16'h0100, 16'h0101, 16'h0102, 16'h0};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 4'b0110, 1'b0, 3'd0, 16'h0);
            chk("r2_inc_addr", last_addr, exp_a[i]);
        end
        rd(3'd2, 16'h0103, "r2_final");

        load(3'd6, 16'h0010);
        load(3'd7, 16'h0013);
        load(3'd0, 16'h0012);
        wrap_cnt = 0;
        exp_a = '{16'h0012, 16'h0013, 16'h0010, 16'h0011};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 4'b0100, 1'b0, 3'd0, 16'h0);
            chk("circ_addr", last_addr, exp_a[i]);
            chk("circ_wrap_at", {15'h0, ifc.wrap}, i == 1 ? 16'h1 : 16'h0);
        end
        chk("circ_wrap_cnt", 16'(wrap_cnt), 16'd1);

        load(3'd4, 16'hFFFE);
        load(3'd7, 16'h0003);
        load(3'd1, 16'h0005);
        wrap_cnt = 0;
        step(1'b1, 1'b1, 4'b1101, 1'b0, 3'd0, 16'h0);
        chk("j_addr0", last_addr, 16'h0005);
        step(1'b1, 1'b1, 4'b1101, 1'b0, 3'd0, 16'h0);
        chk("j_addr1", last_addr, 16'h0003);
        rd(3'd1, 16'h0001, "r1_final");
        chk("j_no_wrap", 16'(wrap_cnt), 16'd0);

        load(3'd3, 16'h0000);
        step(1'b1, 1'b1, 4'b1011, 1'b0, 3'd0, 16'h0);
        rd(3'd3, 16'hFFFF, "r3_dec");
        step(1'b1, 1'b1, 4'b0111, 1'b1, 3'd3, 16'h0040);
        rd(3'd3, 16'h0040, "r3_load_wins");

        step(1'b0, 1'b1, 4'b0111, 1'b1, 3'd3, 16'h1234);
        rd(3'd3, 16'h0040, "cen_low_r3");
        step(1'b0, 1'b1, 4'b0100, 1'b1, 3'd6, 16'hFFFF);
        rd(3'd6, 16'h0010, "cen_low_rb");

        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0), 4'($urandom),
                 1'($urandom_range(0, 3) == 0), 3'($urandom),
                 $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 6)));
        end

        @(negedge clk);
        ifc.cen = 1'b1;
        ifc.ram_access = 1'b1;
        ifc.reg_load = 1'b1;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 8; i++) begin
            ifc.reg_sel = 3'(i);
            ifc.y_field = 4'(i);
            #1;
            chk("mid_rst_reg", ifc.reg_dout, 16'h0);
            chk("mid_rst_addr", ifc.ram_addr, 16'h0);
        end
        chk("mid_rst_wrap", {15'h0, ifc.wrap}, 16'h0);
        @(posedge clk);
        ifc.cen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) rd(3'(i), 16'h0, "post_rst_reg");
        step(1'b1, 1'b1, 4'b0100, 1'b0, 3'd0, 16'h0);
        rd(3'd0, 16'h0001, "post_rst_fresh");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
